tx_shift: RTL and testbench

//  Serializes one 128-bit block (e.g. AES ciphertext) into 16 bytes for the

---
 rtl/tx_shift_if.sv | 22 ++
 rtl/tx_shift.sv | 91 +++++++++
 tb/tb_tx_shift.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tx_shift_if.sv
// rtl/tx_shift_if.sv - block load / UART byte handshake bundle for tx_shift
interface tx_shift_if #(
    parameter int NBYTES = 16
);
    logic [8*NBYTES-1:0] din;
    logic                load;
    logic                tx_done;
    logic [7:0]          dout;
    logic                tx_start;
    logic                busy;
    logic                shift_done;

    modport master (
        output din, load, tx_done,
        input  dout, tx_start, busy, shift_done
    );

    modport slave (
        input  din, load, tx_done,
        output dout, tx_start, busy, shift_done
    );
endinterface

// File: rtl/tx_shift.sv
// rtl/tx_shift.sv - serialize one NBYTES block to the UART tx, MSB byte first
module tx_shift #(
    parameter int NBYTES = 16
) (
    input  logic      clk,
    input  logic      reset,
    tx_shift_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    data_q, data_d;
    logic [CW-1:0]   ctr_q, ctr_d;
    logic [7:0]      dout_q, dout_d;
    logic            tx_start_q, tx_start_d;
    logic            busy_q, busy_d;
    logic            shift_done_q, shift_done_d;
    logic [W-1:0]    data_sh;

    assign data_sh = data_q << 8;

    // Outputs are computed one cycle ahead so every port comes straight off a flop.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        ctr_d        = ctr_q;
        dout_d       = dout_q;
        tx_start_d   = 1'b0;
        busy_d       = busy_q;
        shift_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    data_d     = bus.din;
                    ctr_d      = '0;
                    busy_d     = 1'b1;
                    tx_start_d = 1'b1;
                    dout_d     = bus.din[W-1 -: 8];
                    state_d    = SEND;
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (bus.tx_done) begin
                    if (ctr_q == LAST) begin
                        busy_d       = 1'b0;
                        shift_done_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        data_d     = data_sh;
                        ctr_d      = ctr_q + CW'(1);
                        dout_d     = data_sh[W-1 -: 8];
                        tx_start_d = 1'b1;
                        state_d    = SEND;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            data_q       <= '0;
            ctr_q        <= '0;
            dout_q       <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            shift_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            ctr_q        <= ctr_d;
            dout_q       <= dout_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            shift_done_q <= shift_done_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.busy       = busy_q;
    assign bus.shift_done = shift_done_q;
endmodule

// File: tb/tb_tx_shift.sv
// tb/tb_tx_shift.sv - scoreboard bench for tx_shift
module tb_tx_shift;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic resp_done = 1'b0;
    logic inj_done = 1'b0;
    int   resp_dly = 10;

    int vectors = 0;
    int miscompares = 0;
    int blk_bytes = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_done_cyc = -10;
    logic [7:0] last_dout = 8'h00;
    logic [7:0] exp_q[$];

    tx_shift_if #(.NBYTES(16)) bus ();

    tx_shift #(.NBYTES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.tx_done = resp_done | inj_done;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_block(input logic [127:0] b);
        for (int i = 0; i < 16; i++) exp_q.push_back(b[127-8*i -: 8]);
    endtask

    // Caller sits at posedge+1; returns at posedge+1 of the SEND cycle.
    task automatic do_load(input logic [127:0] d);
        logic [7:0] top;
        top = d[127:120];
        bus.din  = d;
        bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        chk("load_latency_tx_start", bus.tx_start, 1'b1);
        chk("load_latency_dout", bus.dout, top);
    endtask

    task automatic wait_bytes(input int n);
        int k;
        k = 0;
        while (blk_bytes < n && k < 3000) begin @(posedge clk); k++; end
        chk("wait_bytes_timeout", blk_bytes >= n, 1'b1);
        #1;
    endtask

    task automatic wait_done();
        int target, k;
        target = done_cnt + 1;
        k = 0;
        while (done_cnt < target && k < 3000) begin @(posedge clk); k++; end
        chk("wait_done_timeout", done_cnt >= target, 1'b1);
        #1;
    endtask

    // UART tx model: answers each tx_start with a tx_done pulse resp_dly cycles later.
    initial begin
        bit aborted;
        forever begin
            @(negedge clk);
            if (bus.tx_start && !reset) begin
                aborted = 1'b0;
                for (int i = 0; i < resp_dly; i++) begin
                    @(posedge clk);
                    if (reset) aborted = 1'b1;
                end
                #1;
                if (!aborted && !reset) resp_done = 1'b1;
                @(posedge clk); #1;
                resp_done = 1'b0;
            end
        end
    end

    // Monitor: pops expected bytes on tx_start, checks block completion on shift_done.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                blk_bytes = 0;
                last_dout = 8'h00;
            end else begin
                if (bus.tx_start) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_tx_start", bus.tx_start, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte_value", bus.dout, e);
                    end
                    chk("busy_during_byte", bus.busy, 1'b1);
                    blk_bytes++;
                    last_dout = bus.dout;
                end else begin
                    chk("dout_stable", bus.dout, last_dout);
                end
                if (bus.tx_done) last_done_cyc = cyc;
                if (bus.shift_done) begin
                    chk("bytes_per_block", blk_bytes, 16);
                    chk("busy_low_at_done", bus.busy, 1'b0);
                    chk("done_latency", cyc, last_done_cyc + 1);
                    done_cnt++;
                    blk_bytes = 0;
                end
            end
        end
    end

    initial begin
        bus.din  = '0;
        bus.load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.dout, bus.tx_start, bus.busy, bus.shift_done}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Test 1: reset mid-idle, then reset with tx_start showing.
        reset = 1'b1; #1;
        chk("idle_reset_outputs", {bus.dout, bus.tx_start, bus.busy, bus.shift_done}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        bus.din  = 128'hFFEEDDCCBBAA99887766554433221100;
        bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        chk("pre_reset_tx_start", bus.tx_start, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_outputs", {bus.dout, bus.tx_start, bus.busy, bus.shift_done}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_reset_busy", bus.busy, 1'b0);

        // Tests 2 and 3: block with slow transmitter, stray load at byte 5.
        resp_dly = 10;
        push_block(128'h00112233445566778899AABBCCDDEEFF);
        do_load(128'h00112233445566778899AABBCCDDEEFF);
        wait_bytes(5);
        bus.din  = '1;
        bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        wait_done();

        // Test 4: tx_done in IDLE, with load, and during SEND.
        @(posedge clk); #1;
        inj_done = 1'b1;
        @(posedge clk); #1;
        inj_done = 1'b0;
        @(posedge clk); #1;
        push_block(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
        bus.din  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        bus.load = 1'b1;
        inj_done = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        @(posedge clk); #1;
        inj_done = 1'b0;
        wait_done();

        // Test 5: reset after 6th byte, then a fresh all-A5 block.
        @(posedge clk); #1;
        push_block(128'hDEADBEEF0123456789ABCDEFCAFEF00D);
        do_load(128'hDEADBEEF0123456789ABCDEFCAFEF00D);
        wait_bytes(6);
        reset = 1'b1; #1;
        chk("midblock_reset_outputs", {bus.dout, bus.tx_start, bus.busy, bus.shift_done}, 0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("no_done_from_old_block", done_cnt, 2);
        push_block({16{8'hA5}});
        do_load({16{8'hA5}});
        wait_done();

        // Test 6: fastest transmitter, load right after shift_done.
        resp_dly = 1;
        @(posedge clk); #1;
        push_block(128'h0123456789ABCDEFFEDCBA9876543210);
        do_load(128'h0123456789ABCDEFFEDCBA9876543210);
        wait_done();
        push_block(128'hFEDCBA98765432100123456789ABCDEF);
        do_load(128'hFEDCBA98765432100123456789ABCDEF);
        wait_done();

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("total_shift_done", done_cnt, 5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
